// File: rtl/xnor_popcount_accumulator.sv
// XNOR-popcount accumulator for the BCNN datapath: per-beat XNOR popcount of
// activation/weight words, summed over NUM_WORDS beats into one neuron result.
module xnor_popcount_accumulator #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4,
  parameter int SUM_WIDTH  = 6,
  localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [WORD_WIDTH-1:0] act_in,
  input  logic [WORD_WIDTH-1:0] weight_in,
  input  logic                  clear,
  output logic [SUM_WIDTH-1:0]  popcount,
  output logic                  valid_out,
  output logic [IDX_WIDTH-1:0]  beat_idx
);

  // The accumulator must hold a full vector of matches without wrapping.
  if (NUM_WORDS < 1 || (1 << SUM_WIDTH) <= WORD_WIDTH * NUM_WORDS) begin : g_bad_params
    $error("xnor_popcount_accumulator: need NUM_WORDS >= 1 and 2**SUM_WIDTH > WORD_WIDTH*NUM_WORDS");
  end

  logic [IDX_WIDTH-1:0]  beat_cnt;
  logic [SUM_WIDTH-1:0]  p1;
  logic                  v1;
  logic                  last1;
  logic [SUM_WIDTH-1:0]  acc;

  logic [WORD_WIDTH-1:0] match;
  logic [SUM_WIDTH-1:0]  beat_pc;
  logic [SUM_WIDTH-1:0]  acc_sum;
  logic                  accept;
  logic                  last_beat;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    match   = ~(act_in ^ weight_in);
    beat_pc = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      beat_pc = beat_pc + SUM_WIDTH'(match[i]);
    end
  end

  assign accept    = valid_in & ~clear;
  assign last_beat = (beat_cnt == IDX_WIDTH'(NUM_WORDS - 1));
  assign acc_sum   = acc + p1;
  assign beat_idx  = beat_cnt;

  // Stage 1: register the per-beat count and tag the closing beat of a vector.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and the two stages behave as a true pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      p1       <= '0;
      v1       <= 1'b0;
      last1    <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      v1       <= 1'b0;
      last1    <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        p1       <= beat_pc;
        last1    <= last_beat;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  // Stage 2: accumulate; on the closing beat publish the sum and restart from
  // zero so the next vector can follow without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      popcount  <= '0;
      valid_out <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      valid_out <= 1'b0;
    end else if (v1) begin
      if (last1) begin
        popcount  <= acc_sum;
        valid_out <= 1'b1;
        acc       <= '0;
      end else begin
        acc       <= acc_sum;
        valid_out <= 1'b0;
      end
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnor_popcount_accumulator.sv
// Directed bench for xnor_popcount_accumulator: a reference model queues each
// expected neuron result with the cycle it must appear in; a monitor pops them.
module tb_xnor_popcount_accumulator;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] act_in = '0;
  logic [W-1:0] weight_in = '0;
  logic [S-1:0] popcount;
  logic         valid_out;
  logic [1:0]   beat_idx;

  xnor_popcount_accumulator #(.WORD_WIDTH(W), .NUM_WORDS(N), .SUM_WIDTH(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .act_in    (act_in),
    .weight_in (weight_in),
    .clear     (clear),
    .popcount  (popcount),
    .valid_out (valid_out),
    .beat_idx  (beat_idx)
  );

  typedef struct {
    logic [S-1:0] value;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_acc = 0;
  int   m_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Results due at or after the abort edge are never produced.
  task automatic model_abort();
    m_acc = 0;
    m_cnt = 0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due >= cyc) sb.delete(i);
    end
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] w);
    act_in    = a;
    weight_in = w;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    m_acc += $countones(~(a ^ w));
    m_cnt++;
    if (m_cnt == N) begin
      sb.push_back('{S'(m_acc), cyc + 1});
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A valid beat is presented alongside clear to show that clear wins.
  task automatic do_clear();
    clear     = 1'b1;
    valid_in  = 1'b1;
    act_in    = 8'h5A;
    weight_in = 8'h5A;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    valid_in = 1'b0;
    model_abort();
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      check("pending_on_valid", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        check("popcount_value", popcount, sb[0].value);
        check("valid_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      check("missing_valid", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] s3_act [4];
    logic [W-1:0] s3_wgt [4];
    s3_act = '{8'hAA, 8'h33, 8'hF0, 8'h0F};
    s3_wgt = '{8'hA0, 8'h33, 8'h0F, 8'h00};

    #12;
    check("reset_popcount", popcount, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_beat_idx", beat_idx, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: all-match vector
    beat(8'h5A, 8'h5A);
    beat(8'h5A, 8'h5A);
    check("s1_beat_idx_mid", beat_idx, 2);
    beat(8'h5A, 8'h5A);
    beat(8'h5A, 8'h5A);
    check("s1_beat_idx_wrap", beat_idx, 0);
    idle(3);
    check("s1_popcount", popcount, 32);
    check("s1_valid_low", valid_out, 0);

    // 2: no matches
    for (int i = 0; i < N; i++) beat(8'hFF, 8'h00);
    idle(3);
    check("s2_popcount", popcount, 0);

    // 3: mixed per-beat counts 6, 8, 0, 4
    for (int i = 0; i < N; i++) beat(s3_act[i], s3_wgt[i]);
    idle(3);
    check("s3_popcount", popcount, 18);

    // 4: same vector with idle gaps
    for (int i = 0; i < N; i++) begin
      beat(s3_act[i], s3_wgt[i]);
      if (i < N - 1) idle(2);
    end
    idle(3);
    check("s4_popcount", popcount, 18);

    // 5: back-to-back vectors
    for (int i = 0; i < N; i++) beat(8'h5A, 8'h5A);
    for (int i = 0; i < N; i++) beat(8'hFF, 8'h00);
    idle(4);
    check("s5_popcount", popcount, 0);

    // 6a: clear mid-vector, then a full vector
    beat(8'h5A, 8'h5A);
    beat(8'h5A, 8'h5A);
    do_clear();
    check("s6a_beat_idx_cleared", beat_idx, 0);
    for (int i = 0; i < N; i++) beat(8'h5A, 8'h5A);
    idle(3);
    check("s6a_popcount", popcount, 32);

    // Completed vector still in stage 1 when clear arrives is dropped
    for (int i = 0; i < N; i++) beat(8'hFF, 8'h00);
    do_clear();
    idle(3);
    check("s6a_discard_holds", popcount, 32);

    // 6b: async reset mid-vector, then a full vector
    beat(8'h5A, 8'h5A);
    beat(8'h5A, 8'h5A);
    reset = 1'b1;
    #2;
    check("s6b_reset_popcount", popcount, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_abort();
    check("s6b_beat_idx", beat_idx, 0);
    for (int i = 0; i < N; i++) beat(8'h5A, 8'h5A);
    check("s6b_popcount_before", popcount, 0);
    idle(3);
    check("s6b_popcount", popcount, 32);

    idle(2);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xnor_popcount_accumulator.md
Name: xnor_popcount_accumulator

Overview:
Upstream neighbour of the threshold activation stage in the BCNN datapath. Streams binary activation and weight words, one word per beat. Per beat, it forms the bitwise XNOR of the two words and computes its popcount. It accumulates that popcount over NUM_WORDS beats and emits one SUM_WIDTH-bit popcount per neuron, with a single-cycle valid pulse. The output pair (popcount, valid_out) connects directly to the activation stage's popcount/valid_in.

Parameters:
WORD_WIDTH, 8, bits per activation/weight beat
NUM_WORDS, 4, beats per neuron dot product (must be >= 1)
SUM_WIDTH, 6, accumulator/output width; 2^SUM_WIDTH must exceed WORD_WIDTH*NUM_WORDS (checked at elaboration)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
valid_in  input  1  act_in/weight_in carry a valid beat this cycle
act_in  input  WORD_WIDTH  binary activation word (1 = +1, 0 = -1)
weight_in  input  WORD_WIDTH  binary weight word
clear  input  1  synchronous abort; discards any partial vector
popcount  output  SUM_WIDTH  accumulated XNOR popcount for the completed vector
valid_out  output  1  one-cycle pulse; popcount is valid this cycle
beat_idx  output  clog2(NUM_WORDS) (min 1)  index of the next beat to be accepted

Behaviour:
- Reset (async, active-high): beat counter = 0, stage-1 registers = 0, accumulator = 0, popcount = 0, valid_out = 0, beat_idx = 0.
- No backpressure. A beat is accepted on every posedge where valid_in = 1 and clear = 0. Idle cycles between beats are allowed and do not disturb the partial sum.
- Stage 1, on an accepted beat:
  - p1 <= popcount(~(act_in ^ weight_in)), zero-extended to SUM_WIDTH.
  - v1 <= 1.
  - last1 <= (beat counter == NUM_WORDS-1).
  - Beat counter increments and wraps from NUM_WORDS-1 to 0.
  - When no beat is accepted, v1 <= 0.
- Stage 2, when v1 = 1:
  - If last1 = 1: popcount <= acc + p1; valid_out <= 1; acc <= 0.
  - Otherwise: acc <= acc + p1; valid_out <= 0.
  - When v1 = 0: valid_out <= 0 and popcount holds its value.
- Latency: if the last beat is sampled at posedge k, valid_out is high for exactly the cycle after posedge k+1 (2-cycle latency). popcount holds its value until the next result.
- Throughput: back-to-back vectors at full rate. The first beat of vector n+1 may be accepted at the same edge that stage 2 finishes vector n; acc restarts from 0 with no bubble.
- Arithmetic: the sum never overflows given the SUM_WIDTH constraint. Unsigned only.
- clear, registered at posedge: beat counter, v1, last1, acc <= 0; valid_out <= 0. Any beat presented in the same cycle is dropped (clear wins). A completed vector still held in stage 1 is discarded without a valid_out pulse. popcount keeps its last value.
- Reset asserted mid-vector: the partial vector is lost and no valid_out is produced for it. The next accepted beat after reset deasserts is beat 0.
- beat_idx = beat counter. NUM_WORDS = 1 means every accepted beat is a last beat.

Test Plan:
All scenarios use defaults (WORD_WIDTH=8, NUM_WORDS=4, SUM_WIDTH=6).
1. Reset, then 4 beats with act=weight=8'h5A -> single valid_out pulse, popcount = 32, exactly 2 cycles after the 4th beat edge. beat_idx returns to 0.
2. 4 beats with act=8'hFF, weight=8'h00 -> popcount = 0, valid_out pulses once.
3. Beats (act, weight) = (AA,A0), (33,33), (F0,0F), (0F,00) -> per-beat counts 6, 8, 0, 4; popcount = 18.
4. Scenario 3 with 2 idle cycles between each beat -> popcount = 18, 2-cycle latency from the last beat. No valid_out before the 4th beat.
5. Scenario 1 vector followed immediately by the scenario 2 vector (8 consecutive valid cycles) -> two valid_out pulses exactly 4 cycles apart, values 32 then 0.
6. Abort cases:
   - 2 beats of all-match, then clear for 1 cycle, then a full all-match vector -> exactly one valid_out, popcount = 32.
   - Repeat using async reset in place of clear -> same result, with popcount = 0 until that pulse.
